// File: rtl/sram_pkg.sv
// Shared types, constants and byte-merge helper for the 1RW+1R masked-write SRAM model.
// Data words wider than SRAM_MAX_DATA_W are rejected at elaboration by the users of merge_bytes.
package sram_pkg;

    typedef enum logic {
        SRAM_CLEAR = 1'b0,
        SRAM_IDLE  = 1'b1
    } sram_state_e;

    localparam int BYTE_W          = 8;
    localparam int SRAM_MAX_DATA_W = 1024;
    localparam int SRAM_MAX_WMASKS = SRAM_MAX_DATA_W / BYTE_W;

    // Bytes whose mask bit is set come from din_word, all others keep old_word.
    function automatic logic [SRAM_MAX_DATA_W-1:0] merge_bytes(
        input logic [SRAM_MAX_DATA_W-1:0] old_word,
        input logic [SRAM_MAX_DATA_W-1:0] din_word,
        input logic [SRAM_MAX_WMASKS-1:0] wmask
    );
        logic [SRAM_MAX_DATA_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < SRAM_MAX_WMASKS; b++) begin
            if (wmask[b]) begin
                merged[b*BYTE_W +: BYTE_W] = din_word[b*BYTE_W +: BYTE_W];
            end else begin
                merged[b*BYTE_W +: BYTE_W] = old_word[b*BYTE_W +: BYTE_W];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_init_ctrl.sv
// Power-on clear sequencer: walks every address once after reset, then raises ready.
// Any reset, including one arriving mid-walk, restarts the walk from address 0.
module sram_init_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    output logic                  o_clr_we,
    output logic [ADDR_WIDTH-1:0] o_clr_addr,
    output logic                  o_ready
);

    sram_state_e           r_state;
    sram_state_e           w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_addr;
    logic [ADDR_WIDTH-1:0] w_clr_addr_nxt;
    logic                  r_ready;
    logic                  w_last;

    assign w_last = (r_clr_addr == {ADDR_WIDTH{1'b1}});

    // State, clear pointer and ready flag registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= SRAM_CLEAR;
            r_clr_addr <= '0;
            r_ready    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
            r_ready    <= (w_state_nxt == SRAM_IDLE);
        end
    end

    // Next-state logic; an illegal state falls back into a fresh clear.
    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        case (r_state)
            SRAM_CLEAR: begin
                w_clr_addr_nxt = r_clr_addr + ADDR_WIDTH'(1);
                if (w_last) begin
                    w_state_nxt = SRAM_IDLE;
                end else begin
                    w_state_nxt = SRAM_CLEAR;
                end
            end
            SRAM_IDLE: begin
                w_state_nxt    = SRAM_IDLE;
                w_clr_addr_nxt = '0;
            end
            default: begin
                w_state_nxt    = SRAM_CLEAR;
                w_clr_addr_nxt = '0;
            end
        endcase
    end

    assign o_clr_we   = (r_state == SRAM_CLEAR);
    assign o_clr_addr = r_clr_addr;
    assign o_ready    = r_ready;

endmodule

// File: rtl/sram_1rw1r_wmask_sky130a.sv
// Behavioural 1RW (byte-masked) + 1R SRAM with power-on clear, ready flag and read-valid strobes.
// Optional SRAM_1RW1R_FWD_EN: a port 1 read colliding with a port 0 write returns the merged word.
module sram_1rw1r_wmask_sky130a
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                         clk0,
    input  logic                         rst0,
    output logic                         ready,
    input  logic                         csb0,
    input  logic                         web0,
    input  logic [DATA_WIDTH/BYTE_W-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0]        addr0,
    input  logic [DATA_WIDTH-1:0]        din0,
    output logic [DATA_WIDTH-1:0]        dout0,
    output logic                         dout0_valid,
    input  logic                         csb1,
    input  logic [ADDR_WIDTH-1:0]        addr1,
    output logic [DATA_WIDTH-1:0]        dout1,
    output logic                         dout1_valid
);

    localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;
    localparam int NUM_WMASKS = DATA_WIDTH / BYTE_W;

    if ((DATA_WIDTH % BYTE_W) != 0 || DATA_WIDTH < BYTE_W) begin : g_bad_data_width
        $error("DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (DATA_WIDTH > SRAM_MAX_DATA_W) begin : g_too_wide
        $error("DATA_WIDTH exceeds SRAM_MAX_DATA_W");
    end

    function automatic logic [DATA_WIDTH-1:0] merge_word(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] din_word,
        input logic [NUM_WMASKS-1:0] wmask
    );
        return DATA_WIDTH'(merge_bytes(SRAM_MAX_DATA_W'(old_word),
                                       SRAM_MAX_DATA_W'(din_word),
                                       SRAM_MAX_WMASKS'(wmask)));
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
    logic                  w_clr_we;
    logic [ADDR_WIDTH-1:0] w_clr_addr;
    logic                  w_ready;
    logic                  w_wr0;
    logic                  w_rd0;
    logic                  w_rd1;
    logic [DATA_WIDTH-1:0] w_old0;
    logic [DATA_WIDTH-1:0] w_old1;
    logic [DATA_WIDTH-1:0] w_merged0;
    logic [DATA_WIDTH-1:0] w_rd1_data;
    logic [DATA_WIDTH-1:0] r_dout0;
    logic [DATA_WIDTH-1:0] r_dout1;
    logic                  r_dout0_valid;
    logic                  r_dout1_valid;

    sram_init_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_init_ctrl (
        .i_clk      (clk0),
        .i_rst      (rst0),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr),
        .o_ready    (w_ready)
    );

    // Port requests are only honoured once the clear walk has finished.
    assign w_wr0     = w_ready & ~csb0 & ~web0;
    assign w_rd0     = w_ready & ~csb0 &  web0;
    assign w_rd1     = w_ready & ~csb1;
    assign w_old0    = r_mem[addr0];
    assign w_old1    = r_mem[addr1];
    assign w_merged0 = merge_word(w_old0, din0, wmask0);

`ifdef SRAM_1RW1R_FWD_EN
    logic w_collide;
    assign w_collide = w_wr0 & w_rd1 & (addr0 == addr1);

    // Port 1 read data with write-through forwarding on a same-address collision.
    always_comb begin
        w_rd1_data = w_old1;
        if (w_collide) begin
            w_rd1_data = merge_word(w_old1, din0, wmask0);
        end else begin
            w_rd1_data = w_old1;
        end
    end
`else
    // Port 1 read data: array contents sampled before this edge's write (read-before-write).
    always_comb begin
        w_rd1_data = w_old1;
    end
`endif

    // Array write: clear walk has priority, otherwise the masked port 0 write.
    always_ff @(posedge clk0) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_wr0) begin
            r_mem[addr0] <= w_merged0;
        end
    end

    // Read data and strobe registers; data holds between reads.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            r_dout0       <= '0;
            r_dout1       <= '0;
            r_dout0_valid <= 1'b0;
            r_dout1_valid <= 1'b0;
        end else begin
            r_dout0_valid <= w_rd0;
            r_dout1_valid <= w_rd1;
            if (w_rd0) begin
                r_dout0 <= w_old0;
            end
            if (w_rd1) begin
                r_dout1 <= w_rd1_data;
            end
        end
    end

    assign ready       = w_ready;
    assign dout0       = r_dout0;
    assign dout1       = r_dout1;
    assign dout0_valid = r_dout0_valid;
    assign dout1_valid = r_dout1_valid;

endmodule

// File: tb/tb_sram_1rw1r_wmask_sky130a.sv
// Scoreboard bench for sram_1rw1r_wmask_sky130a: directed scenarios plus randomized traffic
// against an array-based reference model; honours SRAM_1RW1R_FWD_EN for collision results.
module tb_sram_1rw1r_wmask_sky130a;

`ifdef SRAM_1RW1R_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int DEPTH = 1024;

    logic        clk0   = 1'b0;
    logic        rst0   = 1'b1;
    logic        csb0   = 1'b1;
    logic        web0   = 1'b1;
    logic [3:0]  wmask0 = 4'h0;
    logic [9:0]  addr0  = 10'h000;
    logic [31:0] din0   = 32'h0;
    logic        csb1   = 1'b1;
    logic [9:0]  addr1  = 10'h000;
    logic        ready;
    logic [31:0] dout0;
    logic        dout0_valid;
    logic [31:0] dout1;
    logic        dout1_valid;

    logic [31:0] mem_m [DEPTH];
    logic [31:0] exp0_q [$];
    logic [31:0] exp1_q [$];
    logic [31:0] last0 = 32'h0;
    logic [31:0] last1 = 32'h0;
    int          clear_left = DEPTH;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk0 = ~clk0;

    sram_1rw1r_wmask_sky130a dut (
        .clk0        (clk0),
        .rst0        (rst0),
        .ready       (ready),
        .csb0        (csb0),
        .web0        (web0),
        .wmask0      (wmask0),
        .addr0       (addr0),
        .din0        (din0),
        .dout0       (dout0),
        .dout0_valid (dout0_valid),
        .csb1        (csb1),
        .addr1       (addr1),
        .dout1       (dout1),
        .dout1_valid (dout1_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Drive one cycle of requests and advance the reference model at the sampling edge.
    task automatic do_cycle(input logic c0, input logic w0, input logic [3:0] m0,
                            input logic [9:0] a0, input logic [31:0] d0,
                            input logic c1, input logic [9:0] a1);
        logic [31:0] old1;
        @(negedge clk0);
        csb0 = c0; web0 = w0; wmask0 = m0; addr0 = a0; din0 = d0; csb1 = c1; addr1 = a1;
        @(posedge clk0);
        if (clear_left > 0) begin
            clear_left--;
        end else begin
            old1 = mem_m[a1];
            if (!c0 && w0) exp0_q.push_back(mem_m[a0]);
            if (!c1) begin
                if (FWD && !c0 && !w0 && a0 == a1) exp1_q.push_back(merge(old1, d0, m0));
                else                                exp1_q.push_back(old1);
            end
            if (!c0 && !w0) mem_m[a0] = merge(mem_m[a0], d0, m0);
        end
    endtask

    task automatic rand_cycle(input bit narrow);
        logic [9:0] a0, a1;
        a0 = narrow ? 10'(10'h010 + $urandom_range(0, 7)) : 10'($urandom_range(0, DEPTH-1));
        a1 = narrow ? 10'(10'h010 + $urandom_range(0, 7)) : 10'($urandom_range(0, DEPTH-1));
        do_cycle(($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
                 a0, $urandom, ($urandom_range(0, 2) == 0), a1);
    endtask

    task automatic apply_reset(input int n);
        @(negedge clk0);
        rst0 = 1'b1; csb0 = 1'b1; csb1 = 1'b1;
        clear_left = DEPTH;
        foreach (mem_m[i]) mem_m[i] = 32'h0;
        repeat (n) @(posedge clk0);
        #2 rst0 = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (n < 3000) begin
            rand_cycle(1'b0);
            n++;
            #2;
            if (ready === 1'b1) break;
        end
        check(name, 32'(n), 32'd1024);
    endtask

    // Monitor: pops the scoreboard whenever a strobe appears and checks the hold rule otherwise.
    initial begin
        logic [31:0] e;
        forever begin
            @(posedge clk0);
            #1;
            check("ready", 32'(ready), 32'(!rst0 && clear_left == 0));
            if (rst0) begin
                check("rst_dout0", dout0, 32'h0);
                check("rst_dout1", dout1, 32'h0);
                check("rst_valids", {30'h0, dout0_valid, dout1_valid}, 32'h0);
                last0 = 32'h0;
                last1 = 32'h0;
            end else begin
                if (dout0_valid) begin
                    if (exp0_q.size() == 0) check("spurious_valid0", 32'(dout0_valid), 32'h0);
                    else begin e = exp0_q.pop_front(); check("dout0", dout0, e); last0 = e; end
                end else if (exp0_q.size() != 0) begin
                    e = exp0_q.pop_front();
                    check("missing_valid0", 32'(dout0_valid), 32'h1);
                    last0 = e;
                end else begin
                    check("hold0", dout0, last0);
                end
                if (dout1_valid) begin
                    if (exp1_q.size() == 0) check("spurious_valid1", 32'(dout1_valid), 32'h0);
                    else begin e = exp1_q.pop_front(); check("dout1", dout1, e); last1 = e; end
                end else if (exp1_q.size() != 0) begin
                    e = exp1_q.pop_front();
                    check("missing_valid1", 32'(dout1_valid), 32'h1);
                    last1 = e;
                end else begin
                    check("hold1", dout1, last1);
                end
            end
        end
    end

    initial begin
        foreach (mem_m[i]) mem_m[i] = 32'h0;
        apply_reset(3);
        wait_ready("clear_len");

        do_cycle(1'b0, 1'b1, 4'h0, 10'h3FF, 32'h0, 1'b1, 10'h000);
        #2;
        check("rd3ff_valid", 32'(dout0_valid), 32'h1);
        check("rd3ff_data", dout0, 32'h0);

        do_cycle(1'b0, 1'b0, 4'hF,    10'h010, 32'hAABBCCDD, 1'b1, 10'h000);
        do_cycle(1'b0, 1'b0, 4'b0101, 10'h010, 32'h11223344, 1'b1, 10'h000);
        do_cycle(1'b0, 1'b0, 4'hF,    10'h020, 32'h5A5A5A5A, 1'b1, 10'h000);
        do_cycle(1'b1, 1'b1, 4'h0,    10'h000, 32'h0,        1'b0, 10'h010);
        #2;
        check("mask_p1", dout1, 32'hAA22CC44);

        do_cycle(1'b0, 1'b1, 4'h0, 10'h010, 32'h0, 1'b0, 10'h020);
        #2;
        check("dual_valids", {30'h0, dout0_valid, dout1_valid}, 32'h3);
        check("dual_d0", dout0, 32'hAA22CC44);
        check("dual_d1", dout1, 32'h5A5A5A5A);

        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b1, 1'b1, 4'h0, 10'h000, 32'h0, 1'b1, 10'h000);
            #2;
            check("hold_d0", dout0, 32'hAA22CC44);
            check("hold_v0", 32'(dout0_valid), 32'h0);
        end

        do_cycle(1'b0, 1'b0, 4'hF,    10'h030, 32'h00000000, 1'b1, 10'h000);
        do_cycle(1'b0, 1'b0, 4'b0011, 10'h030, 32'hFFFFFFFF, 1'b0, 10'h030);
        #2;
        check("coll_d1", dout1, FWD ? 32'h0000FFFF : 32'h00000000);
        do_cycle(1'b1, 1'b1, 4'h0, 10'h000, 32'h0, 1'b0, 10'h030);
        #2;
        check("coll_mem", dout1, 32'h0000FFFF);

        apply_reset(2);
        repeat (500) rand_cycle(1'b0);
        apply_reset(1);
        wait_ready("clear_restart");
        do_cycle(1'b1, 1'b1, 4'h0, 10'h000, 32'h0, 1'b0, 10'h010);
        #2;
        check("cleared_010", dout1, 32'h0);

        repeat (3000) rand_cycle($urandom_range(0, 3) != 0);
        repeat (3) do_cycle(1'b1, 1'b1, 4'h0, 10'h000, 32'h0, 1'b1, 10'h000);
        #2;
        check("q0_drained", 32'(exp0_q.size()), 32'h0);
        check("q1_drained", 32'(exp1_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
